// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader state encoding and stream framing constants
package imem_loader_pkg;
  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, WRITE, DONE, ERR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake (byte_valid/byte_data/byte_ready) plus instruction-memory write bus (imem_we/imem_addr/imem_wdata); master = upstream+memory side, slave = loader
interface imem_loader_if #(parameter int ADDR_W = 32, parameter int data_width = 32);
  logic byte_valid;
  logic [7:0] byte_data;
  logic byte_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [data_width-1:0] imem_wdata;
  modport master(output byte_valid, byte_data, input byte_ready, imem_we, imem_addr, imem_wdata);
  modport slave(input byte_valid, byte_data, output byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler: inserts strobed bytes little-endian into a word (clk, rst active-low async, strobe, data in; word, word_full pulse out)
module imem_loader_word_assembler import imem_loader_pkg::*; #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe,
  input  logic [7:0]   data,
  output logic [W-1:0] word,
  output logic         word_full
);
  logic [1:0] idx;
  assign word_full = strobe && idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      word <= '0;
    end else if (strobe) begin
      word[8*idx +: 8] <= data;
      idx <= idx + 2'd1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader, byte stream -> imem words, holds core in reset until loaded (clk, rst active-low async, bus slave, core_rst_n/load_done/load_err out)
module imem_loader import imem_loader_pkg::*; #(
  parameter int data_width = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus,
  output logic            core_rst_n,
  output logic            load_done,
  output logic            load_err
);
  localparam int CNT_W = 8 * HDR_BYTES;
  state_t state, state_nx;
  logic [CNT_W-1:0] count, word_idx, hdr;
  logic [ADDR_W-1:0] addr;
  logic [data_width-1:0] word;
  logic accept, word_full;
  assign accept = bus.byte_valid && bus.byte_ready;
  assign hdr = {bus.byte_data, count[7:0]};
  assign bus.byte_ready = state inside {CNT_LO, CNT_HI, DATA};
  assign bus.imem_we = state == WRITE;
  assign bus.imem_addr = addr;
  assign bus.imem_wdata = word;
  assign core_rst_n = state == DONE;
  assign load_done = state == DONE;
  assign load_err = state == ERR;
  imem_loader_word_assembler #(.W(data_width)) u_asm (
    .clk(clk),
    .rst(rst),
    .strobe(accept && state == DATA),
    .data(bus.byte_data),
    .word(word),
    .word_full(word_full)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      CNT_LO: state_nx = accept ? CNT_HI : CNT_LO;
      CNT_HI: state_nx = !accept ? CNT_HI : hdr == '0 ? DONE : hdr > CNT_W'(DEPTH) ? ERR : DATA;
      DATA:   state_nx = word_full ? WRITE : DATA;
      WRITE:  state_nx = word_idx + CNT_W'(1) == count ? DONE : DATA;
      default: state_nx = state;
    endcase
  end
  // addr is captured as the write begins so it never advances past the last word written
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= CNT_LO;
      count <= '0;
      word_idx <= '0;
      addr <= '0;
    end else begin
      state <= state_nx;
      if (accept && state == CNT_LO) count[7:0] <= bus.byte_data;
      if (accept && state == CNT_HI) count[15:8] <= bus.byte_data;
      if (word_full) addr <= ADDR_W'({word_idx, 2'b00});
      if (state == WRITE) word_idx <= word_idx + CNT_W'(1);
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader against a stream-level reference model
module tb_imem_loader;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  logic clk = 0;
  logic rst = 0;
  logic core_rst_n, load_done, load_err;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  bit prev_done = 0;
  wr_t sb[$];
  wr_t wr_log[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  imem_loader_if #(.ADDR_W(32), .data_width(32)) bus ();
  imem_loader #(.data_width(32), .DEPTH(64), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .core_rst_n(core_rst_n),
    .load_done(load_done),
    .load_err(load_err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && bus.imem_we) begin
      wr_log.push_back('{bus.imem_addr, bus.imem_wdata});
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("wr_addr", bus.imem_addr, w.addr);
        check("wr_data", bus.imem_wdata, w.data);
      end
      last_we_cyc = cyc;
    end
    if (rst && load_done && !prev_done && last_we_cyc >= 0) check("done_latency", cyc, last_we_cyc + 1);
    prev_done = load_done;
  end
  task automatic model(input logic [7:0] b[$], output bit ed, output bit ee);
    int cnt, n;
    ed = 0;
    ee = 0;
    if (b.size() < 2) return;
    cnt = int'(b[0]) + 256 * int'(b[1]);
    if (cnt == 0) begin ed = 1; return; end
    if (cnt > 64) begin ee = 1; return; end
    n = (b.size() - 2) / 4;
    if (n >= cnt) begin n = cnt; ed = 1; end
    for (int i = 0; i < n; i++)
      sb.push_back('{32'(4 * i), {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]}});
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.byte_valid = 0;
    #2 rst = 0;
    #1;
    check("rst_byte_ready", 32'(bus.byte_ready), 1);
    check("rst_imem_we", 32'(bus.imem_we), 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_err", 32'(load_err), 0);
    sb.delete();
    wr_log.delete();
    last_we_cyc = -1;
    @(negedge clk);
    rst = 1;
  endtask
  task automatic send(input logic [7:0] b, input bit rnd, input int bound, output bit acc);
    acc = 0;
    if (rnd) repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.byte_valid = 0;
    end
    @(negedge clk);
    bus.byte_valid = 1;
    bus.byte_data = b;
    for (int i = 0; i < bound; i++) begin
      if (bus.byte_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic load(input logic [7:0] b[$], input bit rnd, output bit ed, output bit ee);
    bit acc;
    model(b, ed, ee);
    foreach (b[i]) begin
      send(b[i], rnd, 50, acc);
      check("byte_accepted", 32'(acc), 1);
    end
    @(negedge clk);
    bus.byte_valid = 0;
  endtask
  task automatic finish_chk(input bit ed, input bit ee);
    bit acc;
    repeat (3) @(negedge clk);
    check("load_done", 32'(load_done), 32'(ed));
    check("load_err", 32'(load_err), 32'(ee));
    check("core_rst_n", 32'(core_rst_n), 32'(ed));
    check("pending_writes", sb.size(), 0);
    check("byte_ready_end", 32'(bus.byte_ready), 32'(!(ed || ee)));
    if (ed || ee) begin
      send(8'h5A, 0, 10, acc);
      check("extra_byte_refused", 32'(acc), 0);
      @(negedge clk);
      bus.byte_valid = 0;
    end
  endtask
  initial begin
    logic [7:0] q[$];
    logic [7:0] prog1[$];
    bit ed, ee;
    int cnt;
    bus.byte_valid = 0;
    bus.byte_data = 0;
    prog1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    repeat (2) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      load(prog1, bit'(pass), ed, ee);
      finish_chk(ed, ee);
      check("p1_wr_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
        check("p1_w0_data", wr_log[0].data, 32'h00500513);
        check("p1_w1_addr", wr_log[1].addr, 32'h4);
        check("p1_w1_data", wr_log[1].data, 32'h00A00593);
      end
    end
    do_reset();
    q = '{8'h00, 8'h00};
    load(q, 0, ed, ee);
    check("zero_cnt_done_now", 32'(load_done), 1);
    finish_chk(ed, ee);
    check("zero_cnt_writes", wr_log.size(), 0);
    do_reset();
    q = '{8'h41, 8'h00};
    load(q, 0, ed, ee);
    finish_chk(ed, ee);
    check("err_writes", wr_log.size(), 0);
    do_reset();
    q = '{8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = 32'h1000_0000 + 32'(i);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    end
    load(q, 0, ed, ee);
    finish_chk(ed, ee);
    check("full_wr_count", wr_log.size(), 64);
    if (wr_log.size() == 64) begin
      check("full_last_addr", wr_log[63].addr, 32'hFC);
      check("full_last_data", wr_log[63].data, 32'h1000_003F);
    end
    for (int r = 0; r < 4; r++) begin
      do_reset();
      cnt = $urandom_range(1, 8);
      q = '{8'(cnt), 8'h00};
      for (int i = 0; i < 4 * cnt; i++) q.push_back(8'($urandom));
      load(q, 1, ed, ee);
      finish_chk(ed, ee);
    end
    do_reset();
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load(q, 1, ed, ee);
    repeat (2) @(negedge clk);
    check("mid_pending", sb.size(), 0);
    check("mid_not_done", 32'(load_done), 0);
    do_reset();
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(q, 0, ed, ee);
    finish_chk(ed, ee);
    check("beef_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      check("beef_addr", wr_log[0].addr, 32'h0);
      check("beef_data", wr_log[0].data, 32'hDEADBEEF);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
